serializer_tx: RTL

SERIALIZER_TX -- requirements
Module: serializer_tx

---
 rtl/serializer_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serializer_tx.sv
// -----------------------------------------------------------------------------
// serializer_tx
// Parallel-in / serial-out frame transmitter. A word is taken over a
// valid/ready handshake, then shifted out LSB first, one bit per rising edge
// with the bit-strobe high. A single-cycle done pulse marks the end of a frame.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           bit-strobe; one bit consumed per edge with en=1 while shifting
//   load_valid   parallel word offered
//   load_data    parallel word (WIDTH bits)
//   load_ready   block can accept a word this cycle
//   shift_out    current serial bit (data register bit 0 while shifting)
//   shift_valid  shift_out consumed this cycle (state==SHIFT && en)
//   busy         frame in progress
//   done         single-cycle pulse after the last bit
//
// State | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for a load handshake, outputs quiet
// SHIFT | frame in flight, one bit per enabled edge
// -----------------------------------------------------------------------------
module serializer_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             shift_out,
    output logic             shift_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        load_ready  = 1'b0;
        busy        = 1'b0;
        shift_valid = 1'b0;
        shift_out   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy        = 1'b1;
                shift_out   = r_data[0];
                shift_valid = en;
                if (en) begin
                    w_step = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_data <= load_data;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_data <= {1'b0, r_data[WIDTH-1:1]};
                // Park the counter at zero after the last bit so it never wraps.
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign done = r_done;

endmodule
